// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-addressable data memory with load/store front end, funct3 sub-word access,
// valid/ready handshakes, post-reset zero sweep and error flag.
// Optional build macro MISALIGN_TRAP_EN: misaligned accesses are flagged as errors instead of
// being performed bytewise with address wrap.
module dmem_lsu #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);
  localparam int NB    = XLEN / 8;
  localparam int WB    = $clog2(NB);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH / NB - 1);

  typedef enum logic [1:0] {INIT, IDLE, RESP} state_t;

  state_t            state, state_nxt;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] cnt;
  logic              acc, legal, err, uns;
  logic [3:0]        size;
  logic [6:0]        sh;
  logic [XLEN-1:0]   raw, shl, ld_s, ld;

  // Decode funct3 into size/sign/legality and build the extended load value.
  // Extension shifts the access to the top of the word and back, arithmetic for signed loads.
  always_comb begin
    size  = 4'd1 << req_funct3[1:0];
    uns   = req_funct3[2];
    legal = req_we ? (req_funct3 inside {3'b000, 3'b001, 3'b010} || (XLEN == 64 && req_funct3 == 3'b011))
                   : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101} ||
                      (XLEN == 64 && req_funct3 inside {3'b011, 3'b110}));
`ifdef MISALIGN_TRAP_EN
    err   = !legal || |(req_addr & ADDR_W'(size - 4'd1));
`else
    err   = !legal;
`endif
    raw   = '0;
    for (int k = 0; k < NB; k++) raw[8*k +: 8] = mem[req_addr + ADDR_W'(k)];
    sh    = 7'(XLEN) - {size, 3'b000};
    shl   = raw << sh;
    ld_s  = $signed(shl) >>> sh;
    ld    = uns ? shl >> sh : ld_s;
  end

  // Handshake and next-state: ready when idle or when the held response is being consumed.
  always_comb begin
    req_ready = state == IDLE || (state == RESP && rsp_ready);
    acc       = req_valid && req_ready;
    state_nxt = state == INIT ? (cnt == LAST ? IDLE : INIT)
              : acc ? RESP
              : (state == RESP && rsp_ready) ? IDLE : state;
  end

  // State, sweep counter and registered response; reset aborts everything and restarts the sweep.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state     <= INIT;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == INIT) cnt <= cnt + 1'b1;
      if (state == INIT && cnt == LAST) init_done <= 1'b1;
      if (acc) begin
        rsp_valid <= 1'b1;
        rsp_err   <= err;
        rsp_rdata <= (err || req_we) ? '0 : ld;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  // Memory writes: zero one word per sweep cycle, otherwise the low bytes of a legal store.
  always_ff @(posedge clock) begin
    if (state == INIT) begin
      for (int k = 0; k < NB; k++) mem[(cnt << WB) + ADDR_W'(k)] <= 8'h00;
    end else if (acc && req_we && !err) begin
      for (int k = 0; k < NB; k++)
        if (k < int'(size)) mem[req_addr + ADDR_W'(k)] <= req_wdata[8*k +: 8];
    end
  end
endmodule
